muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/div_iter.sv | 57 +++++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// op-class helper functions and the controller state encoding.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MADDU = 3'd5;
   localparam logic [2:0] OP_MSUB  = 3'd6;
   localparam logic [2:0] OP_MSUBU = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Signed variants are the even op codes.
   function automatic logic is_signed(input logic [2:0] op);
      logic r;
      case (op)
         OP_MULT, OP_DIV, OP_MADD, OP_MSUB:     r = 1'b1;
         OP_MULTU, OP_DIVU, OP_MADDU, OP_MSUBU: r = 1'b0;
         default:                               r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Accumulating multiplies (MADD/MADDU/MSUB/MSUBU).
   function automatic logic is_acc(input logic [2:0] op);
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
// load captures the operands; each step retires one quotient bit (MSB first).
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;

   // Trial subtraction of the divisor from the shifted partial remainder;
   // bit WIDTH of the difference is the borrow (restore when set).
   always_comb begin
      w_shift = {r_rem, r_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_dvs};
   end

   // Partial remainder / quotient shift registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= {WIDTH{1'b0}};
         r_quo <= {WIDTH{1'b0}};
         r_dvs <= {WIDTH{1'b0}};
      end else if (load) begin
         r_rem <= {WIDTH{1'b0}};
         r_quo <= dividend;
         r_dvs <= divisor;
      end else if (step) begin
         if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end
      end else begin
         r_rem <= r_rem;
         r_quo <= r_quo;
         r_dvs <= r_dvs;
      end
   end

   assign quotient  = r_quo;
   assign remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, start/done handshake,
// multiply-accumulate/subtract and flush. Drives the EX stall while busy.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic               flush,
   input  logic [1:0]         hilo_we,
   input  logic [WIDTH-1:0]   hilo_wdata,
   output logic               stall,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [2*WIDTH-1:0] hilo
);

   localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             r_state;
   logic [2:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_done;
   logic [2*WIDTH-1:0] r_result;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_pipe [MUL_CYCLES];

   logic               w_accept;
   logic [2*WIDTH-1:0] w_ext_a;
   logic [2*WIDTH-1:0] w_ext_b;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_q_neg;
   logic               w_r_neg;
   logic [2*WIDTH-1:0] w_mul_res;
   logic [2*WIDTH-1:0] w_div_res;

   assign w_accept = (r_state == ST_IDLE) & start & ~flush;

   // Full-width product of the incoming operands and divider magnitudes;
   // both are captured on the accept edge.
   always_comb begin
      if (is_signed(op)) begin
         w_ext_a = {{WIDTH{src_a[WIDTH-1]}}, src_a};
         w_ext_b = {{WIDTH{src_b[WIDTH-1]}}, src_b};
         w_mag_a = src_a[WIDTH-1] ? ({WIDTH{1'b0}} - src_a) : src_a;
         w_mag_b = src_b[WIDTH-1] ? ({WIDTH{1'b0}} - src_b) : src_b;
      end else begin
         w_ext_a = {{WIDTH{1'b0}}, src_a};
         w_ext_b = {{WIDTH{1'b0}}, src_b};
         w_mag_a = src_a;
         w_mag_b = src_b;
      end
      w_prod = w_ext_a * w_ext_b;
   end

   // Multiply latency chain: stage 0 loads on accept, the last stage is
   // consumed on the MUL->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_CYCLES; i++) r_pipe[i] <= {(2*WIDTH){1'b0}};
      end else begin
         if (w_accept) r_pipe[0] <= w_prod;
         else          r_pipe[0] <= r_pipe[0];
         for (int i = 1; i < MUL_CYCLES; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (w_accept & is_div(op)),
      .step      (r_state == ST_DIV),
      .dividend  (w_mag_a),
      .divisor   (w_mag_b),
      .quotient  (w_quo),
      .remainder (w_rem)
   );

   // Final multiply result, folding in HI/LO for the accumulating ops.
   always_comb begin
      if (is_acc(r_op)) begin
         if (is_sub(r_op)) w_mul_res = {r_hi, r_lo} - r_pipe[MUL_CYCLES-1];
         else              w_mul_res = {r_hi, r_lo} + r_pipe[MUL_CYCLES-1];
      end else begin
         w_mul_res = r_pipe[MUL_CYCLES-1];
      end
   end

   // Sign fix-up of the magnitude divide; divide-by-zero returns all-ones
   // quotient and the untouched dividend as remainder.
   always_comb begin
      w_q_neg = is_signed(r_op) & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
      w_r_neg = is_signed(r_op) & r_a[WIDTH-1];
      if (r_b == {WIDTH{1'b0}}) begin
         w_div_res = {r_a, {WIDTH{1'b1}}};
      end else begin
         w_div_res = {(w_r_neg ? ({WIDTH{1'b0}} - w_rem) : w_rem),
                      (w_q_neg ? ({WIDTH{1'b0}} - w_quo) : w_quo)};
      end
   end

   // Controller FSM with registered done/result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_op     <= 3'd0;
         r_a      <= {WIDTH{1'b0}};
         r_b      <= {WIDTH{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_done   <= 1'b0;
         r_result <= {(2*WIDTH){1'b0}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= op;
                  r_a     <= src_a;
                  r_b     <= src_b;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_state <= is_div(op) ? ST_DIV : ST_MUL;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
                  r_state  <= ST_DONE;
                  r_done   <= 1'b1;
                  r_result <= w_mul_res;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DIV: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_state <= ST_FIX;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_FIX: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state  <= ST_DONE;
                  r_done   <= 1'b1;
                  r_result <= w_div_res;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // HI/LO registers: the completing op takes priority over MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= {WIDTH{1'b0}};
         r_lo <= {WIDTH{1'b0}};
      end else if (r_state == ST_DONE) begin
         r_hi <= r_result[2*WIDTH-1:WIDTH];
         r_lo <= r_result[WIDTH-1:0];
      end else begin
         r_hi <= hilo_we[1] ? hilo_wdata : r_hi;
         r_lo <= hilo_we[0] ? hilo_wdata : r_lo;
      end
   end

   assign stall  = w_accept | (r_state == ST_MUL) | (r_state == ST_DIV) | (r_state == ST_FIX);
   assign done   = r_done;
   assign result = r_result;
   assign hilo   = {r_hi, r_lo};

endmodule
